char_text_buffer: RTL and testbench

//  Multi-row character buffer for the VGA text overlay: ROWS x COLS codes of CHAR_W bits.

---
 rtl/char_text_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_char_text_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_text_buffer.sv
// char_text_buffer
//   Character buffer behind the VGA text overlay. It holds ROWS x COLS character
//   codes of CHAR_W bits each, stored at the linear address row*COLS + col.
//   The host writes codes either by explicit (row,col) or through a cursor that
//   advances by one cell after each write. The pixel side maps (xcoor,ycoor) to a
//   character code and the offsets inside the glyph, with two cycles of latency.
//   A sweep state machine fills the array with BLANK after reset and on clear_req.
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   xcoor_i, ycoor_i        current pixel position
//   wr_en_i, wr_mode_i      write strobe; mode 0 = addressed, mode 1 = cursor
//   wr_row_i, wr_col_i      target cell for an addressed write
//   wr_data_i               code to store
//   clear_req_i             single-cycle pulse that starts a clear sweep
//   wr_ready_o, busy_o      FSM is IDLE / FSM is CLEAR
//   char_out_o              code for the pixel presented two cycles earlier
//   glyph_x_o, glyph_y_o    pixel position inside the glyph
//   char_valid_o            pixel is inside the text window and the FSM is IDLE
module char_text_buffer #(
   parameter int              CHAR_W  = 6,
   parameter int              COLS    = 80,
   parameter int              ROWS    = 4,
   parameter int              GLYPH_W = 8,
   parameter int              GLYPH_H = 10,
   parameter int              X_START = 0,
   parameter int              Y_START = 100,
   parameter logic [CHAR_W-1:0] BLANK = 6'h3F,
   localparam int             ROW_W   = $clog2(ROWS),
   localparam int             COL_W   = $clog2(COLS),
   localparam int             GX_W    = $clog2(GLYPH_W),
   localparam int             GY_W    = $clog2(GLYPH_H)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [9:0]        xcoor_i,
   input  logic [8:0]        ycoor_i,
   input  logic              wr_en_i,
   input  logic              wr_mode_i,
   input  logic [ROW_W-1:0]  wr_row_i,
   input  logic [COL_W-1:0]  wr_col_i,
   input  logic [CHAR_W-1:0] wr_data_i,
   input  logic              clear_req_i,
   output logic              wr_ready_o,
   output logic              busy_o,
   output logic [CHAR_W-1:0] char_out_o,
   output logic [GX_W-1:0]   glyph_x_o,
   output logic [GY_W-1:0]   glyph_y_o,
   output logic              char_valid_o
);

   localparam int DEPTH  = ROWS * COLS;
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_ptr_q;
   logic [ROW_W-1:0]    cur_row_q;
   logic [COL_W-1:0]    cur_col_q;
   logic                busy_q, ready_q;

   logic [CHAR_W-1:0]   mem [DEPTH];

   // ---------------- sweep FSM and cursor ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_CLEAR;
         clr_ptr_q <= '0;
         cur_row_q <= '0;
         cur_col_q <= '0;
         busy_q    <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q   <= S_IDLE;
                  clr_ptr_q <= '0;
                  busy_q    <= 1'b0;
                  ready_q   <= 1'b1;
               end else begin
                  clr_ptr_q <= clr_ptr_q + 1'b1;
               end
            end
            default: begin
               if (clear_req_i) begin
                  // A write in the same cycle still lands; the cursor restarts anyway.
                  state_q   <= S_CLEAR;
                  clr_ptr_q <= '0;
                  cur_row_q <= '0;
                  cur_col_q <= '0;
                  busy_q    <= 1'b1;
                  ready_q   <= 1'b0;
               end else if (wr_en_i && wr_mode_i) begin
                  if (cur_col_q == COL_W'(COLS - 1)) begin
                     cur_col_q <= '0;
                     cur_row_q <= (cur_row_q == ROW_W'(ROWS - 1)) ? '0 : cur_row_q + 1'b1;
                  end else begin
                     cur_col_q <= cur_col_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // ---------------- write port ----------------
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [CHAR_W-1:0]   mem_wdata;
   logic                addr_ok;

   assign addr_ok = (int'(wr_row_i) < ROWS) && (int'(wr_col_i) < COLS);

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_ptr_q;
      mem_wdata = BLANK;
      if (state_q == S_CLEAR) begin
         mem_we = 1'b1;
      end else if (wr_en_i) begin
         mem_wdata = wr_data_i;
         if (wr_mode_i) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(cur_row_q) * ADDR_W'(COLS) + ADDR_W'(cur_col_q);
         end else if (addr_ok) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(wr_row_i) * ADDR_W'(COLS) + ADDR_W'(wr_col_i);
         end
      end
   end

   // Held off during reset so the reset cycle itself leaves the array untouched.
   always_ff @(posedge clk_i) begin
      if (!rst_i && mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // ---------------- pixel stage 1 ----------------
   // 12-bit differences: a pixel left of / above the window wraps to >= 1024,
   // which the upper-bound compare rejects, so one compare per axis suffices.
   logic [11:0]       dx, dy, dx_w, dy_w;
   logic              in_win_d, in_win_q;
   logic [ROW_W-1:0]  row_d, row_q;
   logic [COL_W-1:0]  col_d, col_q;
   logic [GX_W-1:0]   gx_d, gx_q;
   logic [GY_W-1:0]   gy_d, gy_q;

   assign dx       = 12'(xcoor_i) - 12'(X_START);
   assign dy       = 12'(ycoor_i) - 12'(Y_START);
   assign in_win_d = (dx < 12'(COLS * GLYPH_W)) && (dy < 12'(ROWS * GLYPH_H));
   assign dx_w     = in_win_d ? dx : '0;
   assign dy_w     = in_win_d ? dy : '0;
   assign col_d    = COL_W'(dx_w >> GX_W);
   assign gx_d     = dx_w[GX_W-1:0];
   assign row_d    = ROW_W'(dy_w / 12'(GLYPH_H));
   assign gy_d     = GY_W'(dy_w % 12'(GLYPH_H));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         in_win_q <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         gx_q     <= '0;
         gy_q     <= '0;
      end else begin
         in_win_q <= in_win_d;
         row_q    <= row_d;
         col_q    <= col_d;
         gx_q     <= gx_d;
         gy_q     <= gy_d;
      end
   end

   // ---------------- pixel stage 2 ----------------
   logic [ADDR_W-1:0] rd_addr;
   logic [CHAR_W-1:0] char_q;
   logic [GX_W-1:0]   glyph_x_q;
   logic [GY_W-1:0]   glyph_y_q;
   logic              valid_q;

   assign rd_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

   // Nonblocking read of mem gives read-before-write on an address collision.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         char_q    <= BLANK;
         glyph_x_q <= '0;
         glyph_y_q <= '0;
         valid_q   <= 1'b0;
      end else if (in_win_q && state_q == S_IDLE) begin
         char_q    <= mem[rd_addr];
         glyph_x_q <= gx_q;
         glyph_y_q <= gy_q;
         valid_q   <= 1'b1;
      end else begin
         char_q    <= BLANK;
         glyph_x_q <= '0;
         glyph_y_q <= '0;
         valid_q   <= 1'b0;
      end
   end

   assign wr_ready_o   = ready_q;
   assign busy_o       = busy_q;
   assign char_out_o   = char_q;
   assign glyph_x_o    = glyph_x_q;
   assign glyph_y_o    = glyph_y_q;
   assign char_valid_o = valid_q;

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: reset sweep, addressed and cursor writes,
// window boundaries, clear sweeps, reset mid-sweep and read/write collision.
module tb_char_text_buffer;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] xcoor;
   logic [8:0] ycoor;
   logic       wr_en, wr_mode;
   logic [1:0] wr_row;
   logic [6:0] wr_col;
   logic [5:0] wr_data;
   logic       clear_req;
   logic       wr_ready, busy;
   logic [5:0] char_out;
   logic [2:0] glyph_x;
   logic [3:0] glyph_y;
   logic       char_valid;

   int n_checks = 0;
   int n_fail   = 0;

   char_text_buffer dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .xcoor_i     (xcoor),
      .ycoor_i     (ycoor),
      .wr_en_i     (wr_en),
      .wr_mode_i   (wr_mode),
      .wr_row_i    (wr_row),
      .wr_col_i    (wr_col),
      .wr_data_i   (wr_data),
      .clear_req_i (clear_req),
      .wr_ready_o  (wr_ready),
      .busy_o      (busy),
      .char_out_o  (char_out),
      .glyph_x_o   (glyph_x),
      .glyph_y_o   (glyph_y),
      .char_valid_o(char_valid)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a pixel and wait for its result to reach the outputs.
   task automatic pix(input int x, input int y);
      xcoor = 10'(x);
      ycoor = 9'(y);
      step();
      step();
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags busy=%b wr_ready=%b expected busy=1 wr_ready=0", busy, wr_ready);
      end
      n_checks++;
      if (char_out !== 6'h3F || glyph_x !== 3'd0 || glyph_y !== 4'd0 || char_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs char=%h gx=%0d gy=%0d valid=%b expected 3f 0 0 0",
                  char_out, glyph_x, glyph_y, char_valid);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         step();
         cnt++;
      end
      n_checks++;
      if (cnt !== 320 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_sweep_len busy_cycles=%0d wr_ready=%b expected 320 and 1", cnt, wr_ready);
      end
      pix(5, 105);
      n_checks++;
      if (char_out !== 6'h3F || char_valid !== 1'b1 || glyph_x !== 3'd5 || glyph_y !== 4'd5) begin
         n_fail++;
         $display("FAIL reset_read char=%h valid=%b gx=%0d gy=%0d expected 3f 1 5 5",
                  char_out, char_valid, glyph_x, glyph_y);
      end
   endtask

   task automatic test_addr_write();
      wr_en = 1'b1; wr_mode = 1'b0; wr_row = 2'd1; wr_col = 7'd2; wr_data = 6'h05;
      step();
      // column 100 is out of range; it would alias onto (1,20) if not dropped
      wr_row = 2'd0; wr_col = 7'd100; wr_data = 6'h11;
      step();
      wr_en = 1'b0;
      pix(16, 112);
      n_checks++;
      if (char_out !== 6'h05 || glyph_x !== 3'd0 || glyph_y !== 4'd2 || char_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL addr_write char=%h gx=%0d gy=%0d valid=%b expected 05 0 2 1",
                  char_out, glyph_x, glyph_y, char_valid);
      end
      pix(160, 110);
      n_checks++;
      if (char_out !== 6'h3F) begin
         n_fail++;
         $display("FAIL addr_drop char=%h expected 3f", char_out);
      end
   endtask

   task automatic test_cursor();
      wr_en = 1'b1; wr_mode = 1'b1;
      for (int i = 0; i < 81; i++) begin
         wr_data = 6'(i % 64);
         step();
      end
      wr_en = 1'b0;
      // back-to-back pixels: (0,79) then (1,0) on consecutive cycles
      xcoor = 10'd632; ycoor = 9'd100;
      step();
      xcoor = 10'd0; ycoor = 9'd110;
      step();
      n_checks++;
      if (char_out !== 6'd15 || glyph_x !== 3'd0 || char_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL cursor_row0_end char=%0d gx=%0d valid=%b expected 15 0 1", char_out, glyph_x, char_valid);
      end
      step();
      n_checks++;
      if (char_out !== 6'd16 || char_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL cursor_row1_start char=%0d valid=%b expected 16 1", char_out, char_valid);
      end
      // cursor at (1,1): fill up to (3,78), then hit (3,79) and wrap to (0,0)
      wr_en = 1'b1;
      wr_data = 6'h01;
      for (int i = 0; i < 238; i++) step();
      wr_data = 6'h21;
      step();
      wr_data = 6'h22;
      step();
      wr_en = 1'b0;
      pix(632, 130);
      n_checks++;
      if (char_out !== 6'h21) begin
         n_fail++;
         $display("FAIL cursor_last_cell char=%h expected 21", char_out);
      end
      pix(0, 100);
      n_checks++;
      if (char_out !== 6'h22) begin
         n_fail++;
         $display("FAIL cursor_wrap char=%h expected 22", char_out);
      end
      pix(624, 130);
      n_checks++;
      if (char_out !== 6'h01) begin
         n_fail++;
         $display("FAIL cursor_fill char=%h expected 01", char_out);
      end
   endtask

   task automatic test_window();
      int xs[3] = '{639, 5, 5};
      int ys[3] = '{99, 140, 99};
      for (int i = 0; i < 3; i++) begin
         pix(xs[i], ys[i]);
         n_checks++;
         if (char_out !== 6'h3F || char_valid !== 1'b0 || glyph_x !== 3'd0 || glyph_y !== 4'd0) begin
            n_fail++;
            $display("FAIL window_out x=%0d y=%0d char=%h valid=%b gx=%0d gy=%0d expected 3f 0 0 0",
                     xs[i], ys[i], char_out, char_valid, glyph_x, glyph_y);
         end
      end
      pix(0, 139);
      n_checks++;
      if (char_out !== 6'h01 || glyph_y !== 4'd9 || glyph_x !== 3'd0 || char_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL window_bottom char=%h gy=%0d gx=%0d valid=%b expected 01 9 0 1",
                  char_out, glyph_y, glyph_x, char_valid);
      end
   endtask

   task automatic test_clear();
      int cnt;
      int cx[6] = '{0, 40, 632, 0, 632, 16};
      int cy[6] = '{100, 100, 100, 110, 130, 112};
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         wr_en = (cnt == 10);
         wr_mode = 1'b0; wr_row = 2'd0; wr_col = 7'd5; wr_data = 6'h07;
         clear_req = (cnt == 150);
         step();
         cnt++;
      end
      wr_en = 1'b0;
      clear_req = 1'b0;
      n_checks++;
      if (cnt !== 320 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_sweep_len busy_cycles=%0d wr_ready=%b expected 320 and 1", cnt, wr_ready);
      end
      for (int i = 0; i < 6; i++) begin
         pix(cx[i], cy[i]);
         n_checks++;
         if (char_out !== 6'h3F || char_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_cell x=%0d y=%0d char=%h valid=%b expected 3f 1",
                     cx[i], cy[i], char_out, char_valid);
         end
      end
   endtask

   task automatic test_rst_mid_sweep();
      int cnt;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 100; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         step();
         cnt++;
      end
      n_checks++;
      if (cnt !== 320) begin
         n_fail++;
         $display("FAIL rst_mid_sweep busy_cycles=%0d expected 320", cnt);
      end
   endtask

   task automatic test_collision();
      xcoor = 10'd0; ycoor = 9'd100;
      step();
      wr_en = 1'b1; wr_mode = 1'b0; wr_row = 2'd0; wr_col = 7'd0; wr_data = 6'h2B;
      step();
      wr_en = 1'b0;
      n_checks++;
      if (char_out !== 6'h3F) begin
         n_fail++;
         $display("FAIL collision_old char=%h expected 3f", char_out);
      end
      step();
      n_checks++;
      if (char_out !== 6'h2B) begin
         n_fail++;
         $display("FAIL collision_new char=%h expected 2b", char_out);
      end
   endtask

   initial begin
      rst = 1'b0; xcoor = '0; ycoor = '0;
      wr_en = 1'b0; wr_mode = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      clear_req = 1'b0;
      #1;
      test_reset();
      test_addr_write();
      test_cursor();
      test_window();
      test_clear();
      test_rst_mid_sweep();
      test_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
